gray_ptr_sync: RTL and testbench
================================

# gray_ptr_sync

Parametrised multi-stage synchroniser for Gray-coded multi-bit values, such as FIFO read/write pointers, crossing into the `clk` domain. It provides:
- a configurable-depth flop chain;
- registered Gray-to-binary conversion;
- a one-cycle update strobe;
- integrity checking that flags any synchronised step changing more than one bit.

It sits on the receiving side of each async FIFO pointer crossing, feeding full/empty logic with a binary pointer.

## Interface
- WIDTH, 6, pointer width in bits; legal range 2..16.
- STAGES, 2, synchroniser flop count before the output register; legal range 2..4.
- clk  input  1  destination-domain clock.
- rstn  input  1  reset, synchronous, active-low.
- gray_in  input  WIDTH  Gray-coded value from the foreign domain; asynchronous to clk.
- err_clr  input  1  synchronous clear of step_err and err_cnt.
- gray_out  output  WIDTH  synchronised Gray value (last chain stage).
- bin_out  output  WIDTH  binary equivalent of gray_out, registered.
- update  output  1  one-cycle strobe: bin_out took a new value this cycle.
- step_err  output  1  sticky flag: a synchronised step changed more than 1 bit.
- err_cnt  output  8  saturating count of multi-bit steps.

## Operation
- Chain s[1..STAGES]: s[1] <= gray_in; s[i] <= s[i-1]; gray_out = s[STAGES].
- Output register stage, on every clk edge when rstn=1:
  - g_d <= gray_out;
  - bin_out <= gray2bin(gray_out), where b[WIDTH-1]=g[WIDTH-1] and b[i]=b[i+1]^g[i];
  - update <= (gray_out != g_d);
  - jump = popcount(gray_out ^ g_d) > 1.
- If jump: step_err <= 1; err_cnt <= err_cnt+1, saturating at 255 (stays 255).
- If err_clr and no jump: step_err <= 0, err_cnt <= 0.
- If err_clr and jump in the same cycle: jump wins; step_err=1, err_cnt=1.
- A single-bit step, including the wrap from MSB-only Gray to 0, is legal: update=1 and no error.
- gray_in is not assumed stable. A multi-bit change at the input appears as a jump unless the chain resolves it into single steps.
- Reset (rstn=0 at a clk edge) clears everything regardless of other inputs, including mid-sequence:
  - all chain flops and g_d reset to 0;
  - gray_out, bin_out, update, step_err and err_cnt reset to 0.
- Parameters outside their legal range cause an elaboration-time error.
- No internal combinational path from gray_in to any output.

## Timing
- A gray_in value captured at edge k appears on gray_out after edge k+STAGES-1.
- bin_out, update and step_err reflect that value after edge k+STAGES.
- Total latency from input capture to bin_out is STAGES+1 edges (3 for the default).
- update is high for exactly one cycle per change of gray_out. Back-to-back changes give update high on consecutive cycles.
- err_clr acts at the next edge. step_err/err_cnt read 0 on the following cycle unless a jump coincided.
- After rstn is released, the first non-zero gray_in is reported as a change relative to 0. A multi-bit first value (e.g. 3) flags an error by design.

## Test plan
- Latency, STAGES=2: gray_in 0->1 sampled at edge 10 -> gray_out=1 after edge 11; bin_out=1 and update=1 after edge 12 only; no error.
- Full count, WIDTH=6: drive Gray of 0..63 then 0, one change every 3 cycles -> bin_out tracks 0..63,0; 64 update pulses; step_err=0 across the wrap (100000->000000).
- Jump: hold 000000, then drive 000011 -> update=1, step_err=1, err_cnt=1 after STAGES+1 edges; step_err stays 1 for later legal steps.
- Clear collision: err_clr=1 in the same cycle a second jump is registered -> step_err=1, err_cnt=1. err_clr alone on the next cycle -> 0/0.
- Saturation: 300 alternating 000000/000011 steps -> err_cnt stops at 255; further jumps keep it at 255.
- Reset mid-operation: rstn=0 for 1 cycle during counting -> all outputs 0 on the next cycle. After release, counting resumes with correct bin_out after STAGES+1 edges; STAGES=3 and STAGES=4 builds show latencies of 4 and 5.

Source files
------------

// File: rtl/gray_ptr_sync.sv
// gray_ptr_sync
//   Receives a Gray-coded multi-bit value (typically an async FIFO pointer)
//   from a foreign clock domain. It passes the value through a STAGES-deep
//   flop chain, converts the result to binary in a registered output stage,
//   strobes update when the value changes, and flags any synchronised step
//   that changes more than one bit.
//
// Ports
//   clk       destination-domain clock
//   rstn      synchronous, active-low reset
//   gray_in   Gray-coded value, asynchronous to clk
//   err_clr   synchronous clear of step_err / err_cnt
//   gray_out  synchronised Gray value (last chain stage)
//   bin_out   registered binary equivalent of gray_out
//   update    one-cycle strobe: bin_out took a new value
//   step_err  sticky multi-bit-step flag
//   err_cnt   saturating count of multi-bit steps
module gray_ptr_sync #(
  parameter int WIDTH  = 6,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] gray_in,
  input  logic             err_clr,
  output logic [WIDTH-1:0] gray_out,
  output logic [WIDTH-1:0] bin_out,
  output logic             update,
  output logic             step_err,
  output logic [7:0]       err_cnt
);

  if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
    $error("gray_ptr_sync: WIDTH must be in 2..16");
  end
  if (STAGES < 2 || STAGES > 4) begin : g_bad_stages
    $error("gray_ptr_sync: STAGES must be in 2..4");
  end

  logic [WIDTH-1:0] sync_q [STAGES];
  logic [WIDTH-1:0] gray_prev_q;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic             update_q, update_d;
  logic             err_q, err_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] diff;
  logic             jump;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= gray_in;
      for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign gray_out = sync_q[STAGES-1];

  // Compare the synchronised value against the one registered last cycle.
  // More than one set bit in the difference means an illegal Gray step;
  // x & (x-1) clears the lowest set bit, so a non-zero result means >1 bit.
  assign diff = gray_out ^ gray_prev_q;
  assign jump = (diff & (diff - WIDTH'(1))) != '0;

  always_comb begin
    bin_d    = '0;
    update_d = (diff != '0);
    err_d    = err_q;
    cnt_d    = cnt_q;

    // Binary bit i is the XOR of all Gray bits at or above i.
    for (int i = 0; i < WIDTH; i++) bin_d[i] = ^(gray_out >> i);

    // A coinciding clear restarts the count at this jump rather than
    // discarding it.
    if (jump) begin
      err_d = 1'b1;
      if (err_clr)             cnt_d = 8'd1;
      else if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
    end else if (err_clr) begin
      err_d = 1'b0;
      cnt_d = 8'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      gray_prev_q <= '0;
      bin_q       <= '0;
      update_q    <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= 8'd0;
    end else begin
      gray_prev_q <= gray_out;
      bin_q       <= bin_d;
      update_q    <= update_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bin_out  = bin_q;
  assign update   = update_q;
  assign step_err = err_q;
  assign err_cnt  = cnt_q;

endmodule

// File: tb/tb_gray_ptr_sync.sv
module tb_gray_ptr_sync;

  logic       clk;
  logic       rstn;
  logic [5:0] gray_in;
  logic       err_clr;

  logic [5:0] g2, b2, g3, b3, g4, b4;
  logic       u2, u3, u4, e2, e3, e4;
  logic [7:0] c2, c3, c4;

  int checks = 0;
  int errors = 0;

  gray_ptr_sync #(.WIDTH(6), .STAGES(2)) dut (
    .clk(clk), .rstn(rstn), .gray_in(gray_in), .err_clr(err_clr),
    .gray_out(g2), .bin_out(b2), .update(u2), .step_err(e2), .err_cnt(c2));

  gray_ptr_sync #(.WIDTH(6), .STAGES(3)) dut3 (
    .clk(clk), .rstn(rstn), .gray_in(gray_in), .err_clr(err_clr),
    .gray_out(g3), .bin_out(b3), .update(u3), .step_err(e3), .err_cnt(c3));

  gray_ptr_sync #(.WIDTH(6), .STAGES(4)) dut4 (
    .clk(clk), .rstn(rstn), .gray_in(gray_in), .err_clr(err_clr),
    .gray_out(g4), .bin_out(b4), .update(u4), .step_err(e4), .err_cnt(c4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: remember what gray_in was at every clock edge, then
  // answer "what should each output show after edge n" by looking back in
  // that history. Edges at or before the latest reset count as value 0.
  logic [5:0] in_at [8192];
  int         n        = 0;
  int         rst_edge = 0;
  bit         m_err    = 1'b0;
  int         m_cnt    = 0;

  function automatic logic [5:0] val(int e);
    if (e <= rst_edge || e < 0) return 6'd0;
    return in_at[e];
  endfunction

  function automatic logic [5:0] g2b(logic [5:0] g);
    logic [5:0] b;
    b = g;
    for (int s = 1; s < 6; s++) b = b ^ (g >> s);
    return b;
  endfunction

  function automatic logic [12:0] exp_out(int s);
    logic [5:0] cur, prv;
    cur = val(n - s);
    prv = val(n - s - 1);
    return {val(n - s + 1), g2b(cur), cur != prv};
  endfunction

  always @(posedge clk) begin
    logic [5:0] a, b;
    if (n < 8191) n = n + 1;
    in_at[n] = gray_in;
    if (!rstn) begin
      rst_edge = n;
      m_err    = 1'b0;
      m_cnt    = 0;
    end else begin
      a = val(n - 2);
      b = val(n - 3);
      if ($countones(a ^ b) > 1) begin
        m_err = 1'b1;
        m_cnt = err_clr ? 1 : (m_cnt == 255 ? 255 : m_cnt + 1);
      end else if (err_clr) begin
        m_err = 1'b0;
        m_cnt = 0;
      end
    end
  end

  task automatic step(input logic [5:0] g, input logic clr);
    gray_in = g;
    err_clr = clr;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(6'($urandom_range(0, 63)), 1'b1);
      checks++;
      if ({g2, b2, u2, e2, c2, g3, b3, u3, e3, c3, g4, b4, u4, e4, c4} !== '0) begin
        errors++;
        $display("FAIL reset_state got %h/%h/%b/%b/%0d exp all zero", g2, b2, u2, e2, c2);
      end
    end
    rstn = 1'b1;
    for (int i = 0; i < 6; i++) step(6'd0, 1'b0);
  endtask

  task automatic test_latency();
    int f2 = -1, f3 = -1, f4 = -1;
    for (int e = 0; e < 7; e++) begin
      step(6'd1, 1'b0);
      if (e == 0) begin
        checks++;
        if (g2 !== 6'd0) begin errors++; $display("FAIL lat_gout_early got %h exp 0", g2); end
      end
      if (e == 1) begin
        checks++;
        if ({g2, b2, u2} !== {6'd1, 6'd0, 1'b0}) begin
          errors++; $display("FAIL lat_edge11 got g=%h b=%h u=%b exp g=1 b=0 u=0", g2, b2, u2);
        end
      end
      if (e == 2) begin
        checks++;
        if ({b2, u2, e2} !== {6'd1, 1'b1, 1'b0}) begin
          errors++; $display("FAIL lat_edge12 got b=%h u=%b e=%b exp b=1 u=1 e=0", b2, u2, e2);
        end
      end
      if (e == 3) begin
        checks++;
        if (u2 !== 1'b0) begin errors++; $display("FAIL lat_update_width got %b exp 0", u2); end
      end
      if (u2 === 1'b1 && f2 < 0) f2 = e;
      if (u3 === 1'b1 && f3 < 0) f3 = e;
      if (u4 === 1'b1 && f4 < 0) f4 = e;
    end
    checks++;
    if ({f2, f3, f4} !== {32'sd2, 32'sd3, 32'sd4}) begin
      errors++; $display("FAIL lat_stages got %0d/%0d/%0d exp 2/3/4", f2, f3, f4);
    end
  endtask

  task automatic test_full_count();
    int pulses = 0;
    for (int i = 0; i <= 64; i++) begin
      for (int h = 0; h < 3; h++) begin
        step(6'((i % 64) ^ ((i % 64) >> 1)), 1'b0);
        if (u2 === 1'b1) pulses++;
        checks++;
        if ({g2, b2, u2} !== exp_out(2)) begin
          errors++; $display("FAIL count_model got %h exp %h", {g2, b2, u2}, exp_out(2));
        end
      end
      checks++;
      if (b2 !== 6'(i % 64)) begin
        errors++; $display("FAIL count_bin got %0d exp %0d", b2, i % 64);
      end
    end
    for (int h = 0; h < 4; h++) begin
      step(6'd0, 1'b0);
      if (u2 === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 64) begin errors++; $display("FAIL count_pulses got %0d exp 64", pulses); end
    checks++;
    if ({e2, c2} !== 9'd0) begin errors++; $display("FAIL count_no_err got %b/%0d exp 0/0", e2, c2); end
  endtask

  task automatic test_jump();
    step(6'b000011, 1'b0);
    step(6'b000011, 1'b0);
    checks++;
    if (e2 !== 1'b0) begin errors++; $display("FAIL jump_early got %b exp 0", e2); end
    step(6'b000011, 1'b0);
    checks++;
    if ({u2, e2, c2} !== {1'b1, 1'b1, 8'd1}) begin
      errors++; $display("FAIL jump_flag got u=%b e=%b c=%0d exp 1/1/1", u2, e2, c2);
    end
    for (int h = 0; h < 4; h++) step(6'b000010, 1'b0);
    checks++;
    if ({b2, e2, c2} !== {6'd3, 1'b1, 8'd1}) begin
      errors++; $display("FAIL jump_sticky got b=%0d e=%b c=%0d exp 3/1/1", b2, e2, c2);
    end
  endtask

  task automatic test_clear_collision();
    step(6'b000101, 1'b0);
    step(6'b000101, 1'b0);
    step(6'b000101, 1'b1);
    checks++;
    if ({e2, c2} !== {1'b1, 8'd1}) begin
      errors++; $display("FAIL clr_collide got e=%b c=%0d exp 1/1", e2, c2);
    end
    step(6'b000101, 1'b1);
    checks++;
    if ({e2, c2} !== {1'b0, 8'd0}) begin
      errors++; $display("FAIL clr_alone got e=%b c=%0d exp 0/0", e2, c2);
    end
    step(6'b000101, 1'b0);
    checks++;
    if ({e2, c2} !== 9'd0) begin errors++; $display("FAIL clr_hold got e=%b c=%0d exp 0/0", e2, c2); end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 300; i++) begin
      step((i % 2 == 0) ? 6'b000000 : 6'b000011, 1'b0);
      if (i == 100) begin
        checks++;
        if ({e2, c2} !== {m_err, 8'(m_cnt)}) begin
          errors++; $display("FAIL sat_mid got e=%b c=%0d exp %b/%0d", e2, c2, m_err, m_cnt);
        end
      end
    end
    checks++;
    if ({e2, c2} !== {1'b1, 8'd255}) begin
      errors++; $display("FAIL sat_255 got e=%b c=%0d exp 1/255", e2, c2);
    end
    for (int i = 0; i < 10; i++) step((i % 2 == 0) ? 6'b000000 : 6'b000011, 1'b0);
    checks++;
    if (c2 !== 8'd255) begin errors++; $display("FAIL sat_hold got %0d exp 255", c2); end
    for (int i = 0; i < 4; i++) step(6'd0, 1'b0);
    step(6'd0, 1'b1);
    checks++;
    if ({e2, c2} !== 9'd0) begin errors++; $display("FAIL sat_clear got e=%b c=%0d exp 0/0", e2, c2); end
    step(6'd0, 1'b0);
  endtask

  task automatic test_reset_mid();
    logic [5:0] seq [4] = '{6'b000011, 6'b000010, 6'b000110, 6'b000111};
    int f2 = -1, f3 = -1, f4 = -1;
    foreach (seq[k]) begin
      step(seq[k], 1'b0);
      step(seq[k], 1'b0);
    end
    rstn = 1'b0;
    step(6'b000111, 1'b1);
    checks++;
    if ({g2, b2, u2, e2, c2, g3, b3, u3, c3, g4, b4, u4, c4} !== '0) begin
      errors++; $display("FAIL rst_mid got %h/%h/%b/%b/%0d exp all zero", g2, b2, u2, e2, c2);
    end
    rstn = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      step(6'b000111, 1'b0);
      if (u2 === 1'b1 && f2 < 0) f2 = e;
      if (u3 === 1'b1 && f3 < 0) f3 = e;
      if (u4 === 1'b1 && f4 < 0) f4 = e;
    end
    checks++;
    if ({f2, f3, f4} !== {32'sd3, 32'sd4, 32'sd5}) begin
      errors++; $display("FAIL rst_resume_lat got %0d/%0d/%0d exp 3/4/5", f2, f3, f4);
    end
    checks++;
    if ({b2, b3, b4, e2, c2} !== {6'd5, 6'd5, 6'd5, 1'b1, 8'd1}) begin
      errors++; $display("FAIL rst_resume_val got %0d/%0d/%0d e=%b c=%0d exp 5/5/5 1/1", b2, b3, b4, e2, c2);
    end
  endtask

  task automatic test_random();
    logic [5:0] g = 6'd0;
    for (int i = 0; i < 1500; i++) begin
      case ($urandom_range(0, 9))
        0, 1:    g = g;
        2:       g = 6'($urandom_range(0, 63));
        default: g = g ^ (6'd1 << $urandom_range(0, 5));
      endcase
      rstn = ($urandom_range(0, 99) != 0);
      step(g, ($urandom_range(0, 15) == 0));
      checks++;
      if ({g2, b2, u2} !== exp_out(2)) begin
        errors++; $display("FAIL rand_s2 got %h exp %h", {g2, b2, u2}, exp_out(2));
      end
      checks++;
      if ({g3, b3, u3} !== exp_out(3)) begin
        errors++; $display("FAIL rand_s3 got %h exp %h", {g3, b3, u3}, exp_out(3));
      end
      checks++;
      if ({g4, b4, u4} !== exp_out(4)) begin
        errors++; $display("FAIL rand_s4 got %h exp %h", {g4, b4, u4}, exp_out(4));
      end
      checks++;
      if ({e2, c2} !== {m_err, 8'(m_cnt)}) begin
        errors++; $display("FAIL rand_err got e=%b c=%0d exp %b/%0d", e2, c2, m_err, m_cnt);
      end
    end
    rstn = 1'b1;
  endtask

  initial begin
    rstn    = 1'b0;
    gray_in = 6'd0;
    err_clr = 1'b0;
    @(negedge clk);
    test_reset();
    test_latency();
    for (int i = 0; i < 4; i++) step(6'd0, 1'b0);
    test_full_count();
    test_jump();
    test_clear_collision();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
